twiddle_seq_gen: RTL

//   Twiddle-factor source for the complex multiplier stage of the N-point radix-2 DIF FFT.
//   On start, streams the N/2 coefficients W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) that one stage needs.

---
 rtl/twiddle_seq_gen_if.sv | 33 +++
 rtl/twiddle_seq_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_seq_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_seq_gen_if
// Description : Coefficient stream carrying packed {real, imag} twiddle
//               factors from the generator to the complex multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface twiddle_seq_gen_if #(
   parameter int NBITScoeff = 11
);
   logic [2*NBITScoeff-1:0] coeff;
   logic                    valid;
   logic                    ready;
   logic                    last;

   // Generator side: drives the coefficient stream, observes backpressure
   modport master (
      output coeff,
      output valid,
      output last,
      input  ready
   );

   // Consumer side
   modport slave (
      input  coeff,
      input  valid,
      input  last,
      output ready
   );
endinterface

`default_nettype wire

// File: rtl/twiddle_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_seq_gen
// Description : Streams the N/2 twiddle factors W_N^k of one radix-2 DIF FFT
//               stage, built from a quarter-wave cosine ROM and symmetry
//               logic, over a valid/ready handshake with a 2-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_seq_gen #(
   parameter int NBITScoeff = 11,
   parameter int N          = 128,
   parameter int LOG2N      = 7,
   parameter int SW         = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SW-1:0]     stage,
   output logic              busy,
   output logic              err,
   twiddle_seq_gen_if.master tw
);

   localparam int KW   = LOG2N - 1;          // butterfly counter / index width
   localparam int FRAC = NBITScoeff - 2;     // fractional bits, 1.0 == 2^FRAC

   localparam logic [KW-1:0] c_quarter    = KW'(N / 4);
   localparam logic [KW-1:0] c_b_last     = KW'(N / 2 - 1);
   localparam logic [KW:0]   c_half       = (KW + 1)'(N / 2);
   localparam logic [SW:0]   c_num_stages = (SW + 1)'(LOG2N);

   // Elaboration-time cosine in Q28 fixed point (Taylor series, |x| <= pi/2),
   // rounded to the coefficient scale. Integer-only so any tool can fold it.
   function automatic logic signed [NBITScoeff-1:0] cos_q(input int m);
      longint one;
      longint x;
      longint term;
      longint sum;
      longint rounded;
      one  = 64'sd1 <<< 28;
      x    = (64'sd843314857 * 64'sd2 * longint'(m)) / longint'(N);
      term = one;
      sum  = one;
      for (int i = 1; i <= 12; i++) begin
         term = -((term * x) / one);
         term = (term * x) / one;
         term = term / longint'((2 * i - 1) * (2 * i));
         sum  = sum + term;
      end
      rounded = (sum + (64'sd1 <<< (27 - FRAC))) >>> (28 - FRAC);
      return NBITScoeff'(rounded);
   endfunction

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic                         w_accept;
   logic                         w_err_nxt;
   logic                         w_adv;
   logic                         w_issue;
   logic [KW-1:0]                r_b;
   logic [SW-1:0]                r_s;
   logic [KW:0]                  w_span;
   logic [KW-1:0]                w_mask;
   logic [KW-1:0]                w_k;
   logic                         w_upper;
   logic [KW-1:0]                w_addr_re;
   logic [KW-1:0]                w_addr_im;
   logic signed [NBITScoeff-1:0] w_rom [0:N/4];

   logic                         r_s1_valid;
   logic signed [NBITScoeff-1:0] r_s1_re;
   logic signed [NBITScoeff-1:0] r_s1_im;
   logic                         r_s1_neg_re;
   logic                         r_s1_last;

   logic                         r_valid;
   logic                         r_last;
   logic [2*NBITScoeff-1:0]      r_coeff;
   logic                         r_err;

   // Quarter-wave table C[0..N/4], fixed constants
   generate
      for (genvar g = 0; g <= N / 4; g++) begin : g_rom
         assign w_rom[g] = cos_q(g);
      end
   endgenerate

   // Whole pipeline moves together; output register empty or being taken
   assign w_adv   = !r_valid || tw.ready;
   assign w_issue = (r_state == S_RUN) && w_adv;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode, start acceptance and bad-stage detection
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if ({1'b0, stage} < c_num_stages) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_RUN;
               end else begin
                  w_err_nxt   = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (w_issue && (r_b == c_b_last)) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_valid && tw.ready && r_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Butterfly counter and latched stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_b <= '0;
         r_s <= '0;
      end else if (w_accept) begin
         r_b <= '0;
         r_s <= stage;
      end else if (w_issue) begin
         r_b <= r_b + 1'b1;
      end
   end

   // k = (b mod (N >> (s+1))) << s, then fold into the quarter-wave table
   always_comb begin
      w_span    = c_half >> r_s;
      w_mask    = KW'(w_span - 1'b1);
      w_k       = (r_b & w_mask) << r_s;
      w_upper   = (w_k > c_quarter);
      w_addr_re = w_upper ? KW'(c_half - {1'b0, w_k}) : w_k;
      w_addr_im = w_upper ? (w_k - c_quarter) : (c_quarter - w_k);
   end

   // Stage 1: registered ROM read plus sign/last tags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_re     <= '0;
         r_s1_im     <= '0;
         r_s1_neg_re <= 1'b0;
         r_s1_last   <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid  <= w_issue;
         r_s1_re     <= w_rom[w_addr_re];
         r_s1_im     <= w_rom[w_addr_im];
         r_s1_neg_re <= w_upper;
         r_s1_last   <= (r_b == c_b_last);
      end
   end

   // Stage 2: apply signs into the packed output register; holds while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_coeff <= '0;
      end else if (w_adv) begin
         r_valid <= r_s1_valid;
         r_last  <= r_s1_valid & r_s1_last;
         if (r_s1_valid) begin
            r_coeff <= {(r_s1_neg_re ? -r_s1_re : r_s1_re), -r_s1_im};
         end
      end
   end

   // One-cycle error pulse for an out-of-range stage request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else        r_err <= w_err_nxt;
   end

   assign tw.coeff = r_coeff;
   assign tw.valid = r_valid;
   assign tw.last  = r_last;
   assign busy     = (r_state != S_IDLE);
   assign err      = r_err;

endmodule

`default_nettype wire
